// File: rtl/button_event_arbiter.sv
// Button event arbiter: collects one-shot press pulses from NUM_BTN buttons,
// grants them round-robin into a small event FIFO and reports lost presses.
// Optional feature macro: BTN_ARB_OVF_CNT_EN enables the saturating
// lost-press counter on ovf_count; without it ovf_count is tied to zero.
module button_event_arbiter #(
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_pulse,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic                       drop_pulse,
  output logic [7:0]                 ovf_count
);

  localparam int unsigned ID_W  = $clog2(NUM_BTN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Architectural state
  logic [NUM_BTN-1:0] pending;
  logic [ID_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ID_W-1:0]    mem [FIFO_DEPTH];

  // Next-state and combinational helpers
  logic [NUM_BTN-1:0] pending_d;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic [CNT_W-1:0]   count_d;
  logic               evt_valid_d;
  logic [ID_W-1:0]    evt_id_d;
  logic               drop_d;
  logic [NUM_BTN-1:0] drop_vec;
  logic [NUM_BTN-1:0] gnt_onehot;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    cand;
  logic               gnt_found;
  logic               grant;
  logic               push;
  logic               pop;

  // Round-robin search over registered pending bits, starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_BTN; off++) begin
      cand = ID_W'(32'(rr_ptr) + off);
      if (!gnt_found && pending[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    // Full queue stalls grants even if a pop happens this cycle
    grant      = gnt_found && (count < DEPTH_C);
    gnt_onehot = grant ? (NUM_BTN'(1) << gnt_id) : '0;
  end

  // Pending/drop, FIFO pointer and head-of-queue next-state logic
  always_comb begin
    push        = grant;
    pop         = evt_valid && evt_ready;
    pending_d   = (pending & ~gnt_onehot) | btn_pulse;
    drop_vec    = btn_pulse & pending & ~gnt_onehot;
    drop_d      = |drop_vec;
    rr_ptr_d    = grant ? ID_W'(gnt_id + ID_W'(1)) : rr_ptr;
    wr_ptr_d    = push ? PTR_W'(wr_ptr + PTR_W'(1)) : wr_ptr;
    rd_ptr_d    = pop ? PTR_W'(rd_ptr + PTR_W'(1)) : rd_ptr;
    count_d     = count;
    evt_id_d    = evt_id;
    case ({push, pop})
      2'b10:   count_d = CNT_W'(count + CNT_W'(1));
      2'b01:   count_d = CNT_W'(count - CNT_W'(1));
      default: count_d = count;
    endcase
    evt_valid_d = (count_d != '0);
    // New head is either the entry being written this edge or a stored one
    if (count_d != '0) begin
      if (push && (wr_ptr == rd_ptr_d)) begin
        evt_id_d = gnt_id;
      end else begin
        evt_id_d = mem[rd_ptr_d];
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      pending    <= pending_d;
      rr_ptr     <= rr_ptr_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      evt_valid  <= evt_valid_d;
      evt_id     <= evt_id_d;
      drop_pulse <= drop_d;
    end
  end

  // Event storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= gnt_id;
    end
  end

`ifdef BTN_ARB_OVF_CNT_EN
  logic [7:0] ovf_q;

  // Saturating lost-press counter, bumped together with drop_pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 8'd0;
    end else if (drop_d && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed, table-driven bench for button_event_arbiter.
module tb_button_event_arbiter;

`ifdef BTN_ARB_OVF_CNT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       drop_pulse;
  logic [7:0] ovf_count;

  int checks;
  int failures;

  button_event_arbiter #(.NUM_BTN(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pulse  (btn_pulse),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .drop_pulse (drop_pulse),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       v;
    logic [1:0] id;
    logic       d;
    logic [7:0] ovf;   // expected value when the counter is built in
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] b, input logic r, input logic v,
                     input logic [1:0] id, input logic d, input logic [7:0] o);
    vec_t e;
    e.btn = b; e.rdy = r; e.v = v; e.id = id; e.d = d; e.ovf = o;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the next rising edge
  task automatic step(input logic [3:0] b, input logic r);
    @(negedge clk);
    btn_pulse = b;
    evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ovf_exp(input logic [7:0] v);
    return (OVF_EN != 0) ? v : 8'd0;
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    btn_pulse = 4'b0;
    evt_ready = 1'b0;

    // Single press, id 2, two-cycle latency, one-cycle valid
    add(4'b0100, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 2, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    // Press on 3 brings rr_ptr back to 0
    add(4'b1000, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 3, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    // Contention: all four at once, delivered 0,1,2,3 back to back
    add(4'b1111, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 1, 2, 0, 0);
    add(4'b0000, 1, 1, 3, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    // Full stall: five presses with consumer blocked, head held at 0
    add(4'b0001, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 0, 0, 0);
    add(4'b0100, 0, 1, 0, 0, 0);
    add(4'b1000, 0, 1, 0, 0, 0);
    add(4'b0001, 0, 1, 0, 0, 0);
    add(4'b0000, 0, 1, 0, 0, 0);
    // Button 1 twice while full: second press is lost
    add(4'b0010, 0, 1, 0, 0, 0);
    add(4'b0010, 0, 1, 0, 1, 1);
    add(4'b0000, 0, 1, 0, 0, 1);
    // Two simultaneous drops give a single drop cycle
    add(4'b0011, 0, 1, 0, 1, 2);
    add(4'b0000, 0, 1, 0, 0, 2);
    // Drain: no pass-through on the first pop, then pending 0 and 1 refill
    add(4'b0000, 1, 1, 1, 0, 2);
    add(4'b0000, 1, 1, 2, 0, 2);
    add(4'b0000, 1, 1, 3, 0, 2);
    add(4'b0000, 1, 1, 0, 0, 2);
    add(4'b0000, 1, 1, 1, 0, 2);
    add(4'b0000, 1, 0, 0, 0, 2);

    // Asynchronous reset values before any clock edge
    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn, tbl[i].rdy);
      check($sformatf("row%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
      if (tbl[i].v) check($sformatf("row%0d_id", i), 32'(evt_id), 32'(tbl[i].id));
      check($sformatf("row%0d_drop", i), 32'(drop_pulse), 32'(tbl[i].d));
      check($sformatf("row%0d_ovf", i), 32'(ovf_count), 32'(ovf_exp(tbl[i].ovf)));
    end

    // Reset mid-operation with three events queued (rr_ptr is 2 here)
    step(4'b0111, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    check("midrst_pre_valid", 32'(evt_valid), 32'd1);
    check("midrst_pre_id", 32'(evt_id), 32'd2);
    @(negedge clk);
    reset     = 1'b0;
    btn_pulse = 4'b1111;
    #1;
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_id", 32'(evt_id), 32'd0);
    check("midrst_ovf", 32'(ovf_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    btn_pulse = 4'b0000;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1);
      check($sformatf("postrst%0d_valid", i), 32'(evt_valid), 32'd0);
      check($sformatf("postrst%0d_drop", i), 32'(drop_pulse), 32'd0);
    end

    // Saturation: fill the queue, then keep re-pressing pending button 0
    step(4'b1111, 0);
    for (int i = 0; i < 4; i++) step(4'b0000, 0);
    step(4'b0001, 0);
    check("sat_fill_valid", 32'(evt_valid), 32'd1);
    check("sat_fill_id", 32'(evt_id), 32'd0);
    check("sat_fill_drop", 32'(drop_pulse), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      step(4'b0001, 0);
      if (i == 254) check("sat_254", 32'(ovf_count), 32'(ovf_exp(8'd254)));
      if (i == 255) check("sat_255", 32'(ovf_count), 32'(ovf_exp(8'd255)));
    end
    check("sat_drop", 32'(drop_pulse), 32'd1);
    check("sat_300", 32'(ovf_count), 32'(ovf_exp(8'd255)));
    step(4'b0000, 0);
    check("sat_drop_end", 32'(drop_pulse), 32'd0);
    check("sat_hold", 32'(ovf_count), 32'(ovf_exp(8'd255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
